// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : Receive buffer behind the UART receiver. Detects rising      |
// |               edges of the receiver's level-type ready flag, pushes the    |
// |               received byte into a circular FIFO, and pops bytes on a      |
// |               single-cycle read strobe from the bus side.                  |
// | Parameters  : DEPTH_LOG2  log2 of FIFO depth (1..8, default 4 = 16 bytes)  |
// | Ports       : clk, rst            clock, synchronous active-high reset     |
// |               rxData, rxReady     byte and ready level from the receiver   |
// |               rdEn                pop strobe                               |
// |               rdData, rdValid     registered popped byte and its pulse     |
// |               empty, full, count  occupancy status                         |
// |               overrun, ovrClr     sticky drop flag and its clear           |
// | Option      : define UART_RX_OVERRUN_EN to build the overrun flag;         |
// |               otherwise overrun is tied 0 and ovrClr is ignored.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rxData,
   input  logic                  rxReady,
   input  logic                  rdEn,
   output logic [7:0]            rdData,
   output logic                  rdValid,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  ovrClr
);

   localparam int                    c_DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   c_CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

   logic [7:0]            r_mem [0:c_DEPTH-1];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [7:0]            r_rd_data;
   logic                  r_rd_valid;
   logic                  r_ready_d;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr;
   logic                  w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL_COUNT);
   assign w_push  = rxReady & ~r_ready_d;
   assign w_pop   = rdEn & ~w_empty;
   // When full, a same-cycle pop frees the slot the write pointer lands on;
   // the read samples the old contents before the write takes effect.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   // Edge register resets to 1 so a ready level held across reset is not a new byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready_d <= 1'b1;
      end else begin
         r_ready_d <= rxReady;
      end
   end

   // Storage array carries no reset.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= rxData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
            r_rd_data <= r_mem[r_rd_ptr];
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef UART_RX_OVERRUN_EN
   logic r_overrun;

   // Set takes priority over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (ovrClr) begin
         r_overrun <= 1'b0;
      end
   end

   assign overrun = r_overrun;
`else
   logic w_unused_ovr;
   assign w_unused_ovr = &{1'b0, ovrClr, w_drop};
   assign overrun      = 1'b0;
`endif

   assign rdData  = r_rd_data;
   assign rdValid = r_rd_valid;
   assign empty   = w_empty;
   assign full    = w_full;
   assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                              |
// | Description : Directed self-checking bench for uart_rx_fifo (16 entries).  |
// |               Overrun expectations follow UART_RX_OVERRUN_EN.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic [7:0] rxData;
   logic       rxReady;
   logic       rdEn;
   logic [7:0] rdData;
   logic       rdValid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
   logic       ovrClr;

   int r_total = 0;
   int r_bad   = 0;

`ifdef UART_RX_OVERRUN_EN
   localparam logic c_OVR_ON = 1'b1;
`else
   localparam logic c_OVR_ON = 1'b0;
`endif

   uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .rxData  (rxData),
      .rxReady (rxReady),
      .rdEn    (rdEn),
      .rdData  (rdData),
      .rdValid (rdValid),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .ovrClr  (ovrClr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      r_total++;
      if (act !== exp) begin
         r_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the edge so outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      rxData  = d;
      rxReady = 1'b1;
      tick();
      rxReady = 1'b0;
      tick();
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      chk({tag, "_valid"}, rdValid, 1);
      chk({tag, "_data"}, rdData, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      logic [7:0] nxt;

      rst = 1'b1; rxData = 8'h00; rxReady = 1'b0; rdEn = 1'b0; ovrClr = 1'b0;
      tick(); tick();
      chk("rst_rdData", rdData, 0);
      chk("rst_rdValid", rdValid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // 1: single byte, ready held high afterwards
      rxData = 8'hA5; rxReady = 1'b1;
      tick(); tick();
      chk("t1_count", count, 1);
      chk("t1_notempty", empty, 0);
      tick(); tick(); tick();
      chk("t1_onepush", count, 1);
      pop_chk("t1_pop", 8'hA5);
      chk("t1_empty", empty, 1);
      tick();
      chk("t1_valid_pulse", rdValid, 0);
      rxReady = 1'b0;
      tick();

      // 2: ready held high through reset
      rxData = 8'h3C; rxReady = 1'b1; rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("t2_count", count, 0);
      chk("t2_empty", empty, 1);
      rxReady = 1'b0;
      tick();

      // 3: fill, drop, drain
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("t3_full", full, 1);
      chk("t3_count", count, 16);
      push(8'hFF);
      chk("t3_drop_count", count, 16);
      chk("t3_overrun", overrun, c_OVR_ON);
      for (int i = 0; i < 16; i++) pop_chk("t3_pop", 8'(i));
      chk("t3_empty", empty, 1);
      ovrClr = 1'b1; tick(); ovrClr = 1'b0;
      chk("t3_ovrclr", overrun, 0);

      // 4: full with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      rxData = 8'h77; rxReady = 1'b1; rdEn = 1'b1;
      tick();
      rxReady = 1'b0; rdEn = 1'b0;
      chk("t4_valid", rdValid, 1);
      chk("t4_data", rdData, 8'h10);
      chk("t4_count", count, 16);
      chk("t4_overrun", overrun, 0);
      tick();
      for (int i = 1; i < 16; i++) pop_chk("t4_pop", 8'(8'h10 + i));
      pop_chk("t4_last", 8'h77);
      chk("t4_empty", empty, 1);

      // 5: read while empty, then push+pop on empty
      rdEn = 1'b1; tick(); rdEn = 1'b0;
      chk("t5_novalid", rdValid, 0);
      chk("t5_hold", rdData, 8'h77);
      rxData = 8'h5A; rxReady = 1'b1; rdEn = 1'b1;
      tick();
      rxReady = 1'b0; rdEn = 1'b0;
      chk("t5_pp_valid", rdValid, 0);
      chk("t5_pp_count", count, 1);
      chk("t5_pp_empty", empty, 0);
      tick();
      pop_chk("t5_pop", 8'h5A);

      // 6: interleaved traffic against a queue model
      nxt = 8'h80;
      for (int i = 0; i < 40; i++) begin
         push(nxt);
         if (q.size() < 16) q.push_back(nxt);
         nxt = nxt + 8'd1;
         chk("t6_cnt_le16", 32'(count <= 5'd16), 1);
         if (q.size() >= 12 || $urandom_range(0, 1) == 1) begin
            b = q.pop_front();
            pop_chk("t6_pop", b);
         end
      end
      chk("t6_count", count, q.size());
      while (q.size() > 0) begin
         b = q.pop_front();
         pop_chk("t6_drain", b);
      end
      chk("t6_empty", empty, 1);

      // Overrun set and clear in the same cycle: set wins
      for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
      rxData = 8'hEE; rxReady = 1'b1; ovrClr = 1'b1;
      tick();
      rxReady = 1'b0; ovrClr = 1'b0;
      chk("t6_setwins", overrun, c_OVR_ON);
      chk("t6_drop_count", count, 16);
      tick();
      ovrClr = 1'b1; tick(); ovrClr = 1'b0;
      chk("t6_clear", overrun, 0);

      // Reset mid-operation
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t7_count", count, 0);
      chk("t7_empty", empty, 1);
      chk("t7_rdData", rdData, 0);

      $display("test done: total=%0d bad=%0d", r_total, r_bad);
      $finish;
   end

endmodule
`default_nettype wire
